// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, latencies and the
// result calculation used at issue time.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MdNone  = 3'd0,
    MdMult  = 3'd1,
    MdMultu = 3'd2,
    MdDiv   = 3'd3,
    MdDivu  = 3'd4,
    MdMthi  = 3'd5,
    MdMtlo  = 3'd6,
    MdRsvd  = 3'd7
  } md_op_e;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  localparam int unsigned MdOpW  = 3;
  localparam int unsigned CntW   = 4;
  localparam int unsigned MulLat = 5;
  localparam int unsigned DivLat = 10;

  localparam logic [CntW-1:0] MulCntInit = CntW'(MulLat - 1);
  localparam logic [CntW-1:0] DivCntInit = CntW'(DivLat - 1);

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  function automatic logic [CntW-1:0] md_cnt_init(md_op_e op);
    logic [CntW-1:0] cnt;
    cnt = (op == MdDiv || op == MdDivu) ? DivCntInit : MulCntInit;
    return cnt;
  endfunction

  // Signed divide works on magnitudes so the MIN_INT / -1 case falls out as
  // quotient 0x80000000, remainder 0 without needing a separate path.
  function automatic md_result_t md_compute(md_op_e op, logic [31:0] a, logic [31:0] b);
    md_result_t  res;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;
    res   = '0;
    prod  = '0;
    mag_a = a[31] ? (~a + 32'd1) : a;
    mag_b = b[31] ? (~b + 32'd1) : b;
    quo   = '0;
    rem   = '0;
    case (op)
      MdMult: begin
        prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MdMultu: begin
        prod   = {32'd0, a} * {32'd0, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      MdDiv: begin
        if (b == 32'd0) begin
          res.hi = a;
          res.lo = 32'hFFFF_FFFF;
        end else begin
          quo    = mag_a / mag_b;
          rem    = mag_a % mag_b;
          res.lo = (a[31] ^ b[31]) ? (~quo + 32'd1) : quo;
          res.hi = a[31] ? (~rem + 32'd1) : rem;
        end
      end
      MdDivu: begin
        if (b == 32'd0) begin
          res.hi = a;
          res.lo = 32'hFFFF_FFFF;
        end else begin
          res.lo = a / b;
          res.hi = a % b;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic               req;
  logic               start;
  logic [MdOpW-1:0]   md_op;
  logic [31:0]        a;
  logic [31:0]        b;
  logic               busy;
  logic [31:0]        hi;
  logic [31:0]        lo;

  modport master (
    output req,
    output start,
    output md_op,
    output a,
    output b,
    input  busy,
    input  hi,
    input  lo
  );

  modport slave (
    input  req,
    input  start,
    input  md_op,
    input  a,
    input  b,
    output busy,
    output hi,
    output lo
  );

endinterface

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit owning HI/LO. The result is computed at issue and
// a countdown models the unit latency before it lands in HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  md_if
);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  md_result_t      res_q, res_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  md_op_e          op;

  assign op = md_op_e'(md_if.md_op);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        // A flush in the issue cycle drops both mult/div issue and MT* writes.
        if (!md_if.req) begin
          if (md_if.start && (op inside {MdMult, MdMultu, MdDiv, MdDivu})) begin
            state_d = StRun;
            cnt_d   = md_cnt_init(op);
            res_d   = md_compute(op, md_if.a, md_if.b);
          end else if (op == MdMthi) begin
            hi_d = md_if.a;
          end else if (op == MdMtlo) begin
            lo_d = md_if.a;
          end
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          hi_d    = res_q.hi;
          lo_d    = res_q.lo;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md_if.busy = (state_q == StRun);
  assign md_if.hi   = hi_q;
  assign md_if.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: cycle-by-cycle compare against a latency/arithmetic
// model plus literal expectations for the documented vectors.
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic chk_en;

  mult_div_unit_if md_if ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .md_if (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers; returns {hi, lo}.
  function automatic logic [63:0] model_res(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          sq;
    longint          sr;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: begin
        sq = sa * sb;
        return sq;
      end
      3'd2: begin
        up = ua * ub;
        return up;
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        up = ua / ub;
        ua = ua % ub;
        return {ua[31:0], up[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  int          m_left;

  always @(posedge clk) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (!md_if.req) begin
      if (md_if.start && (md_if.md_op inside {[3'd1:3'd4]})) begin
        m_pend <= model_res(md_if.md_op, md_if.a, md_if.b);
        m_left <= (md_if.md_op <= 3'd2) ? 5 : 10;
      end else if (md_if.md_op == 3'd5) begin
        m_hi <= md_if.a;
      end else if (md_if.md_op == 3'd6) begin
        m_lo <= md_if.a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'd0, md_if.busy}, {31'd0, (m_left != 0)});
      chk("cyc_hi", md_if.hi, m_hi);
      chk("cyc_lo", md_if.lo, m_lo);
    end
  end

  // Holds the op for one cycle, returns at the negedge just after the issue edge.
  task automatic drive(logic st, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic rq);
    @(negedge clk);
    md_if.start = st;
    md_if.md_op = op;
    md_if.a     = a;
    md_if.b     = b;
    md_if.req   = rq;
    @(negedge clk);
    md_if.start = 1'b0;
    md_if.md_op = 3'd0;
    md_if.req   = 1'b0;
  endtask

  task automatic run_op(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                        int exp_lat, logic [31:0] exp_hi, logic [31:0] exp_lo);
    int n;
    drive(1'b1, op, a, b, 1'b0);
    n = 0;
    while (md_if.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_hi"}, md_if.hi, exp_hi);
    chk({name, "_lo"}, md_if.lo, exp_lo);
  endtask

  initial begin
    int n;
    checks      = 0;
    failures    = 0;
    chk_en      = 1'b0;
    reset       = 1'b1;
    md_if.req   = 1'b0;
    md_if.start = 1'b1;
    md_if.md_op = 3'd1;
    md_if.a     = 32'd3;
    md_if.b     = 32'd4;
    repeat (3) @(negedge clk);
    md_if.start = 1'b0;
    md_if.md_op = 3'd0;
    chk_en = 1'b1;
    chk("rst_busy", {31'd0, md_if.busy}, 32'd0);
    chk("rst_hi", md_if.hi, 32'd0);
    chk("rst_lo", md_if.lo, 32'd0);
    reset = 1'b0;

    run_op("mult",      3'd1, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg",   3'd3, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 3'd4, 32'd7,         32'd0,         10, 32'd7,         32'hFFFF_FFFF);
    run_op("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000);
    run_op("div_negb",  3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD);
    run_op("divu_big",  3'd4, 32'hFFFF_FFFF, 32'h10,        10, 32'hF,         32'h0FFF_FFFF);
    run_op("div_zero",  3'd3, 32'hFFFF_FFF0, 32'd0,         10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // Flushed issue and flushed MTLO leave everything untouched.
    drive(1'b1, 3'd3, 32'd50, 32'd5, 1'b1);
    chk("flush_busy", {31'd0, md_if.busy}, 32'd0);
    drive(1'b0, 3'd6, 32'h1234, 32'd0, 1'b1);
    chk("flush_busy2", {31'd0, md_if.busy}, 32'd0);
    chk("flush_hi", md_if.hi, 32'hFFFF_FFF0);
    chk("flush_lo", md_if.lo, 32'hFFFF_FFFF);

    drive(1'b0, 3'd5, 32'h1111_2222, 32'd0, 1'b0);
    chk("mthi_busy", {31'd0, md_if.busy}, 32'd0);
    chk("mthi_hi", md_if.hi, 32'h1111_2222);
    drive(1'b1, 3'd6, 32'h3333_4444, 32'd0, 1'b0);
    chk("mtlo_busy", {31'd0, md_if.busy}, 32'd0);
    chk("mtlo_lo", md_if.lo, 32'h3333_4444);

    drive(1'b1, 3'd0, 32'd9, 32'd9, 1'b0);
    drive(1'b1, 3'd7, 32'd9, 32'd9, 1'b0);
    chk("nop_busy", {31'd0, md_if.busy}, 32'd0);
    chk("nop_hi", md_if.hi, 32'h1111_2222);
    chk("nop_lo", md_if.lo, 32'h3333_4444);

    // In-flight DIV survives a req pulse, a second start and an MTHI.
    drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    n = 0;
    for (int c = 0; c < 14; c++) begin
      if (md_if.busy) n++;
      case (c)
        2: md_if.req = 1'b1;
        3: begin
          md_if.req   = 1'b0;
          md_if.start = 1'b1;
          md_if.md_op = 3'd2;
          md_if.a     = 32'd2;
          md_if.b     = 32'd3;
        end
        4: begin
          md_if.start = 1'b0;
          md_if.md_op = 3'd5;
          md_if.a     = 32'hDEAD_0000;
        end
        5: md_if.md_op = 3'd0;
        default: ;
      endcase
      @(negedge clk);
    end
    chk("run_lat", n, 32'd10);
    chk("run_hi", md_if.hi, 32'd2);
    chk("run_lo", md_if.lo, 32'd14);

    // Reset mid-run aborts the op, then MTHI still works.
    drive(1'b1, 3'd1, 32'd5, 32'd6, 1'b0);
    chk("abort_busy_pre", {31'd0, md_if.busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, md_if.busy}, 32'd0);
    chk("abort_hi", md_if.hi, 32'd0);
    chk("abort_lo", md_if.lo, 32'd0);
    drive(1'b0, 3'd5, 32'hCAFE_BABE, 32'd0, 1'b0);
    chk("post_mthi", md_if.hi, 32'hCAFE_BABE);
    repeat (12) @(negedge clk);
    chk("post_lo", md_if.lo, 32'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
